// File: rtl/arbiter_rn_4ph.sv
// arbiter_rn_4ph
// ---------------------------------------------------------------------------
// Clocked N-port four-phase arbiter/merge. Client 4-phase handshakes on
// r/a are forwarded one at a time to a shared downstream channel r0/a0.
// Arbitration is round-robin (RR=1) or fixed priority with port 0 highest
// (RR=0). Protocol violations set a sticky err flag.
//
// Optional feature: define ARBITER_RN_4PH_SYNC_EN to pass r and a0 through
// 2-flop synchronizers. This adds 2 cycles to every input-to-output latency.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   r[N]     in   client requests
//   a[N]     out  client acknowledges, one-hot or zero
//   r0       out  shared downstream request
//   a0       in   shared downstream acknowledge
//   gnt_idx  out  index of the granted port, valid while busy=1
//   busy     out  high from grant until the handshake returns to zero
//   err      out  sticky protocol-error flag
// ---------------------------------------------------------------------------
module arbiter_rn_4ph #(
    parameter int N  = 4,
    parameter bit RR = 1'b1,
    localparam int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  r,
    output logic [N-1:0]  a,
    output logic          r0,
    input  logic          a0,
    output logic [GW-1:0] gnt_idx,
    output logic          busy,
    output logic          err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_RTZ  = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] ptr_next;
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic          found;
    // Set on the way out of RTZ so that IDLE always lasts one full cycle
    // before the next grant.
    logic          cool;

    logic [N-1:0]  r_s;
    logic          a0_s;

`ifdef ARBITER_RN_4PH_SYNC_EN
    logic [N-1:0]  r_m;
    logic          a0_m;

    // Two-flop synchronizers for clients living in another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m  <= '0;
            r_s  <= '0;
            a0_m <= 1'b0;
            a0_s <= 1'b0;
        end else begin
            r_m  <= r;
            r_s  <= r_m;
            a0_m <= a0;
            a0_s <= a0_m;
        end
    end
`else
    assign r_s  = r;
    assign a0_s = a0;
`endif

    // Winner search: scan from the pointer (round-robin) or from port 0
    // (fixed priority); the first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (RR) begin
                idx = GW'((int'(ptr) + k) % N);
            end else begin
                idx = GW'(k);
            end
            if (!found && r_s[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ptr_next = (gnt_idx == GW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // Handshake FSM. Errors only raise err; they never divert the path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a       <= '0;
            r0      <= 1'b0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
            ptr     <= '0;
            cool    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a0_s) begin
                        err <= 1'b1;
                    end
                    if (cool) begin
                        cool <= 1'b0;
                    end else if (found) begin
                        gnt_idx <= win;
                        busy    <= 1'b1;
                        r0      <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!r_s[gnt_idx]) begin
                        err <= 1'b1;
                    end
                    if (a0_s) begin
                        a[gnt_idx] <= 1'b1;
                        state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!a0_s) begin
                        err <= 1'b1;
                    end
                    if (!r_s[gnt_idx]) begin
                        r0    <= 1'b0;
                        state <= S_RTZ;
                    end
                end
                default: begin
                    if (!a0_s) begin
                        a     <= '0;
                        busy  <= 1'b0;
                        cool  <= 1'b1;
                        state <= S_IDLE;
                        if (RR) begin
                            ptr <= ptr_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule
